cva6_l2_tlb_sa: RTL and testbench

CVA6_L2_TLB_SA -- requirements
Module: cva6_l2_tlb_sa

---
 rtl/cva6_l2_tlb_sa_pkg.sv | 37 +++
 rtl/cva6_l2_tlb_way_sel.sv | 37 +++
 rtl/cva6_l2_tlb_sa.sv | 177 +++++++++++++++++
 tb/tb_cva6_l2_tlb_sa.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cva6_l2_tlb_sa_pkg.sv
// Shared types, default widths and index helpers for the CVA6 L2 set-associative TLB.
package cva6_l2_tlb_sa_pkg;

  localparam int unsigned VPN_W      = 27;
  localparam int unsigned ASID_W     = 16;
  localparam int unsigned VMID_W     = 14;
  localparam int unsigned PPN_W      = 44;
  localparam int unsigned PERM_W     = 10;
  localparam int unsigned NR_ENTRIES = 128;
  localparam int unsigned ASSOC      = 4;

  // Index width that never collapses to zero bits (a single way still needs a 1-bit pointer).
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned SET_W = idx_w(NR_ENTRIES / ASSOC);
  localparam int unsigned WAY_W = idx_w(ASSOC);

  typedef struct packed {
    logic [VPN_W-1:0]  vpn;
    logic [ASID_W-1:0] asid;
    logic [VMID_W-1:0] vmid;
  } tlb_tag_t;

  typedef struct packed {
    tlb_tag_t          tag;
    logic [PPN_W-1:0]  ppn;
    logic [PERM_W-1:0] perm;
  } tlb_entry_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } tlb_state_e;

endpackage

// File: rtl/cva6_l2_tlb_way_sel.sv
// Way encoding for one TLB set: lowest-index hit way for lookups, replacement way for fills.
module cva6_l2_tlb_way_sel #(
  parameter int unsigned Assoc = 4,
  parameter int unsigned WayW  = 2
) (
  input  logic [Assoc-1:0] lu_match_i,
  input  logic [Assoc-1:0] fill_match_i,
  input  logic [Assoc-1:0] fill_valid_i,
  input  logic [WayW-1:0]  rr_i,
  output logic             lu_hit_o,
  output logic [WayW-1:0]  lu_way_o,
  output logic [WayW-1:0]  fill_way_o,
  output logic             fill_evict_o,
  output logic [WayW-1:0]  rr_next_o
);

  function automatic logic [WayW-1:0] first_one(input logic [Assoc-1:0] v);
    first_one = '0;
    for (int i = int'(Assoc) - 1; i >= 0; i--)
      if (v[i]) first_one = WayW'(i);
  endfunction

  assign lu_hit_o = |lu_match_i;
  assign lu_way_o = first_one(lu_match_i);

  // Same-tag overwrite beats a free way, which beats evicting the round-robin victim.
  always_comb begin
    fill_way_o   = rr_i;
    fill_evict_o = 1'b0;
    if (|fill_match_i)        fill_way_o = first_one(fill_match_i);
    else if (!(&fill_valid_i)) fill_way_o = first_one(~fill_valid_i);
    else                       fill_evict_o = 1'b1;
  end

  assign rr_next_o = (rr_i == WayW'(Assoc - 1)) ? '0 : rr_i + WayW'(1);

endmodule

// File: rtl/cva6_l2_tlb_sa.sv
// Set-associative L2 TLB: 1-cycle lookups, single-entry fills, filtered set-by-set flush walk.
module cva6_l2_tlb_sa
  import cva6_l2_tlb_sa_pkg::*;
#(
  parameter int unsigned NrEntries = NR_ENTRIES,
  parameter int unsigned Assoc     = ASSOC,
  parameter int unsigned VpnWidth  = VPN_W,
  parameter int unsigned PpnWidth  = PPN_W,
  parameter int unsigned AsidWidth = ASID_W,
  parameter int unsigned VmidWidth = VMID_W,
  parameter int unsigned PermWidth = PERM_W
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 lu_req_i,
  output logic                 lu_ready_o,
  input  logic [VpnWidth-1:0]  lu_vpn_i,
  input  logic [AsidWidth-1:0] lu_asid_i,
  input  logic [VmidWidth-1:0] lu_vmid_i,
  output logic                 lu_valid_o,
  output logic                 lu_hit_o,
  output logic [PpnWidth-1:0]  lu_ppn_o,
  output logic [PermWidth-1:0] lu_perm_o,
  input  logic                 fill_valid_i,
  input  logic [VpnWidth-1:0]  fill_vpn_i,
  input  logic [AsidWidth-1:0] fill_asid_i,
  input  logic [VmidWidth-1:0] fill_vmid_i,
  input  logic [PpnWidth-1:0]  fill_ppn_i,
  input  logic [PermWidth-1:0] fill_perm_i,
  input  logic                 flush_i,
  input  logic                 flush_by_asid_i,
  input  logic                 flush_by_vmid_i,
  input  logic [AsidWidth-1:0] flush_asid_i,
  input  logic [VmidWidth-1:0] flush_vmid_i,
  output logic                 flush_busy_o
);

  // The field widths must match the package entry layout; the parameters exist for interface visibility.
  localparam int unsigned NrSets = NrEntries / Assoc;
  localparam int unsigned SetW   = idx_w(NrSets);
  localparam int unsigned WayW   = idx_w(Assoc);

  tlb_state_e state_q, state_d;
  logic lu_accept, fill_en, flush_start, flush_step, flush_last;

  tlb_entry_t       entry_q [NrSets][Assoc];
  logic [Assoc-1:0] valid_q [NrSets];
  logic [WayW-1:0]  rr_q    [NrSets];

  logic [SetW-1:0]      flush_idx_q;
  logic                 by_asid_q, by_vmid_q;
  logic [AsidWidth-1:0] f_asid_q;
  logic [VmidWidth-1:0] f_vmid_q;

  tlb_tag_t         lu_tag, fill_tag;
  logic [SetW-1:0]  lu_set, fill_set;
  logic [Assoc-1:0] lu_match, fill_match, flush_clr;
  logic             lu_hit, fill_evict;
  logic [WayW-1:0]  lu_way, fill_way, rr_next;
  tlb_entry_t       lu_rd;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (flush_i)    state_d = ST_FLUSH;
      ST_FLUSH: if (flush_last) state_d = ST_IDLE;
      default:                  state_d = ST_IDLE;
    endcase
  end

  // A flush request in IDLE blocks both the lookup and the fill issued alongside it.
  always_comb begin
    lu_ready_o   = 1'b0;
    fill_en      = 1'b0;
    flush_start  = 1'b0;
    flush_step   = 1'b0;
    flush_busy_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        lu_ready_o  = !fill_valid_i && !flush_i;
        fill_en     = fill_valid_i && !flush_i;
        flush_start = flush_i;
      end
      ST_FLUSH: begin
        flush_step   = 1'b1;
        flush_busy_o = 1'b1;
      end
      default: ;
    endcase
  end

  assign lu_accept  = lu_req_i && lu_ready_o;
  assign flush_last = (flush_idx_q == SetW'(NrSets - 1));

  assign lu_tag   = '{vpn: lu_vpn_i, asid: lu_asid_i, vmid: lu_vmid_i};
  assign fill_tag = '{vpn: fill_vpn_i, asid: fill_asid_i, vmid: fill_vmid_i};
  assign lu_set   = lu_vpn_i[SetW-1:0];
  assign fill_set = fill_vpn_i[SetW-1:0];

  for (genvar w = 0; w < Assoc; w++) begin : g_way
    assign lu_match[w]   = valid_q[lu_set][w] && (entry_q[lu_set][w].tag == lu_tag);
    assign fill_match[w] = valid_q[fill_set][w] && (entry_q[fill_set][w].tag == fill_tag);
    assign flush_clr[w]  = (!by_asid_q || entry_q[flush_idx_q][w].tag.asid == f_asid_q) &&
                           (!by_vmid_q || entry_q[flush_idx_q][w].tag.vmid == f_vmid_q);
  end

  cva6_l2_tlb_way_sel #(.Assoc(Assoc), .WayW(WayW)) u_way_sel (
    .lu_match_i   (lu_match),
    .fill_match_i (fill_match),
    .fill_valid_i (valid_q[fill_set]),
    .rr_i         (rr_q[fill_set]),
    .lu_hit_o     (lu_hit),
    .lu_way_o     (lu_way),
    .fill_way_o   (fill_way),
    .fill_evict_o (fill_evict),
    .rr_next_o    (rr_next)
  );

  // Payload storage carries no reset; only the valid bits qualify it.
  always_ff @(posedge clk_i) begin
    if (fill_en) entry_q[fill_set][fill_way] <= '{tag: fill_tag, ppn: fill_ppn_i, perm: fill_perm_i};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int s = 0; s < int'(NrSets); s++) begin
        valid_q[s] <= '0;
        rr_q[s]    <= '0;
      end
    end else if (fill_en) begin
      valid_q[fill_set][fill_way] <= 1'b1;
      if (fill_evict) rr_q[fill_set] <= rr_next;
    end else if (flush_step) begin
      valid_q[flush_idx_q] <= valid_q[flush_idx_q] & ~flush_clr;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      flush_idx_q <= '0;
      by_asid_q   <= 1'b0;
      by_vmid_q   <= 1'b0;
      f_asid_q    <= '0;
      f_vmid_q    <= '0;
    end else if (flush_start) begin
      flush_idx_q <= '0;
      by_asid_q   <= flush_by_asid_i;
      by_vmid_q   <= flush_by_vmid_i;
      f_asid_q    <= flush_asid_i;
      f_vmid_q    <= flush_vmid_i;
    end else if (flush_step) begin
      flush_idx_q <= flush_idx_q + SetW'(1);
    end
  end

  assign lu_rd = entry_q[lu_set][lu_way];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lu_valid_o <= 1'b0;
      lu_hit_o   <= 1'b0;
      lu_ppn_o   <= '0;
      lu_perm_o  <= '0;
    end else begin
      lu_valid_o <= lu_accept;
      lu_hit_o   <= lu_accept && lu_hit;
      lu_ppn_o   <= (lu_accept && lu_hit) ? lu_rd.ppn  : '0;
      lu_perm_o  <= (lu_accept && lu_hit) ? lu_rd.perm : '0;
    end
  end

endmodule

// File: tb/tb_cva6_l2_tlb_sa.sv
// Bench for cva6_l2_tlb_sa: directed table, multi-cycle flush/reset sequences, random ops vs. a set model.
module tb_cva6_l2_tlb_sa;
  localparam int NS = 32;
  localparam int NA = 4;

  logic        clk = 1'b0, rst_ni = 1'b0;
  logic        lu_req_i = 1'b0, lu_ready_o, lu_valid_o, lu_hit_o;
  logic [26:0] lu_vpn_i = '0, fill_vpn_i = '0;
  logic [15:0] lu_asid_i = '0, fill_asid_i = '0, flush_asid_i = '0;
  logic [13:0] lu_vmid_i = '0, fill_vmid_i = '0, flush_vmid_i = '0;
  logic [43:0] lu_ppn_o, fill_ppn_i = '0;
  logic [9:0]  lu_perm_o, fill_perm_i = '0;
  logic        fill_valid_i = 1'b0, flush_i = 1'b0;
  logic        flush_by_asid_i = 1'b0, flush_by_vmid_i = 1'b0, flush_busy_o;

  always #5 clk = ~clk;

  cva6_l2_tlb_sa dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .lu_req_i(lu_req_i), .lu_ready_o(lu_ready_o),
    .lu_vpn_i(lu_vpn_i), .lu_asid_i(lu_asid_i), .lu_vmid_i(lu_vmid_i),
    .lu_valid_o(lu_valid_o), .lu_hit_o(lu_hit_o), .lu_ppn_o(lu_ppn_o), .lu_perm_o(lu_perm_o),
    .fill_valid_i(fill_valid_i), .fill_vpn_i(fill_vpn_i), .fill_asid_i(fill_asid_i),
    .fill_vmid_i(fill_vmid_i), .fill_ppn_i(fill_ppn_i), .fill_perm_i(fill_perm_i),
    .flush_i(flush_i), .flush_by_asid_i(flush_by_asid_i), .flush_by_vmid_i(flush_by_vmid_i),
    .flush_asid_i(flush_asid_i), .flush_vmid_i(flush_vmid_i), .flush_busy_o(flush_busy_o)
  );

  int n_tests = 0, n_fail = 0;

  // Reference model: per set, NA slots with a round-robin victim counter.
  bit          m_vld  [NS][NA];
  logic [26:0] m_vpn  [NS][NA];
  logic [15:0] m_asid [NS][NA];
  logic [13:0] m_vmid [NS][NA];
  logic [43:0] m_ppn  [NS][NA];
  logic [9:0]  m_perm [NS][NA];
  int          m_rr   [NS];

  function automatic void m_clear();
    for (int s = 0; s < NS; s++) begin
      m_rr[s] = 0;
      for (int w = 0; w < NA; w++) m_vld[s][w] = 1'b0;
    end
  endfunction

  function automatic bit m_same(int s, int w, logic [26:0] v, logic [15:0] a, logic [13:0] m);
    return m_vld[s][w] && m_vpn[s][w] == v && m_asid[s][w] == a && m_vmid[s][w] == m;
  endfunction

  function automatic void m_fill(logic [26:0] v, logic [15:0] a, logic [13:0] m, logic [43:0] p, logic [9:0] pm);
    int s, w;
    s = int'(v) % NS;
    w = -1;
    for (int i = 0; i < NA; i++) if (w < 0 && m_same(s, i, v, a, m)) w = i;
    for (int i = 0; i < NA; i++) if (w < 0 && !m_vld[s][i]) w = i;
    if (w < 0) begin
      w = m_rr[s];
      m_rr[s] = (m_rr[s] + 1) % NA;
    end
    m_vld[s][w] = 1'b1; m_vpn[s][w] = v; m_asid[s][w] = a; m_vmid[s][w] = m;
    m_ppn[s][w] = p;    m_perm[s][w] = pm;
  endfunction

  function automatic void m_lookup(logic [26:0] v, logic [15:0] a, logic [13:0] m,
                                   output bit h, output logic [43:0] p, output logic [9:0] pm);
    int s;
    s = int'(v) % NS;
    h = 1'b0; p = '0; pm = '0;
    for (int i = 0; i < NA; i++)
      if (!h && m_same(s, i, v, a, m)) begin
        h = 1'b1; p = m_ppn[s][i]; pm = m_perm[s][i];
      end
  endfunction

  function automatic void m_flush(bit ba, logic [15:0] a, bit bv, logic [13:0] m);
    for (int s = 0; s < NS; s++)
      for (int w = 0; w < NA; w++)
        if ((!ba || m_asid[s][w] == a) && (!bv || m_vmid[s][w] == m)) m_vld[s][w] = 1'b0;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic do_fill(input logic [26:0] v, input logic [15:0] a, input logic [13:0] m,
                         input logic [43:0] p, input logic [9:0] pm);
    fill_valid_i = 1'b1; fill_vpn_i = v; fill_asid_i = a; fill_vmid_i = m;
    fill_ppn_i = p; fill_perm_i = pm;
    @(posedge clk); #1;
    fill_valid_i = 1'b0;
    m_fill(v, a, m, p, pm);
  endtask

  task automatic do_lookup(input logic [26:0] v, input logic [15:0] a, input logic [13:0] m,
                           input bit eh, input logic [43:0] ep, input logic [9:0] epm, input string nm);
    lu_req_i = 1'b1; lu_vpn_i = v; lu_asid_i = a; lu_vmid_i = m;
    #1 chk({nm, ".ready"}, 64'(lu_ready_o), 64'd1);
    @(posedge clk); #1;
    lu_req_i = 1'b0;
    chk({nm, ".valid"}, 64'(lu_valid_o), 64'd1);
    chk({nm, ".hit"},   64'(lu_hit_o),   64'(eh));
    chk({nm, ".ppn"},   64'(lu_ppn_o),   64'(ep));
    chk({nm, ".perm"},  64'(lu_perm_o),  64'(epm));
  endtask

  task automatic model_lookup(input logic [26:0] v, input logic [15:0] a, input logic [13:0] m, input string nm);
    bit h; logic [43:0] p; logic [9:0] pm;
    m_lookup(v, a, m, h, p, pm);
    do_lookup(v, a, m, h, p, pm, nm);
  endtask

  // Counts busy cycles from the current sample; optionally pokes flush/fill mid-walk (both must be ignored).
  task automatic wait_flush(input bit disturb, input string nm);
    int cnt = 0;
    while (flush_busy_o && cnt < 100) begin
      cnt++;
      if (cnt == 1) chk({nm, ".ready_in_flush"}, 64'(lu_ready_o), 64'd0);
      if (disturb) begin
        fill_valid_i = (cnt == 5);
        flush_i      = (cnt == 5);
      end
      @(posedge clk); #1;
    end
    fill_valid_i = 1'b0; flush_i = 1'b0;
    chk({nm, ".busy_cycles"}, 64'(cnt), 64'(NS));
  endtask

  task automatic do_flush(input bit ba, input logic [15:0] a, input bit bv, input logic [13:0] m,
                          input bit disturb, input string nm);
    flush_by_asid_i = ba; flush_asid_i = a; flush_by_vmid_i = bv; flush_vmid_i = m;
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    wait_flush(disturb, nm);
    m_flush(ba, a, bv, m);
  endtask

  typedef struct {
    bit          fill;
    logic [26:0] vpn;
    logic [15:0] asid;
    logic [13:0] vmid;
    logic [43:0] ppn;   // fill payload, or expected lookup result
    logic [9:0]  perm;
    bit          hit;
  } vec_t;
  vec_t tbl[$];

  function automatic void add_f(logic [26:0] v, logic [15:0] a, logic [43:0] p, logic [9:0] pm);
    tbl.push_back('{1'b1, v, a, 14'd1, p, pm, 1'b0});
  endfunction
  function automatic void add_l(logic [26:0] v, logic [15:0] a, logic [13:0] m, bit h, logic [43:0] p, logic [9:0] pm);
    tbl.push_back('{1'b0, v, a, m, p, pm, h});
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    m_clear();
    add_f(27'h25, 16'd3, 44'hABC, 10'h00F);
    add_l(27'h25, 16'd3, 14'd1, 1'b1, 44'hABC, 10'h00F);
    add_f(27'h00, 16'd3, 44'h100, 10'h001);
    add_f(27'h20, 16'd3, 44'h101, 10'h002);
    add_f(27'h40, 16'd5, 44'h102, 10'h003);
    add_f(27'h60, 16'd3, 44'h103, 10'h004);
    add_f(27'h80, 16'd5, 44'h104, 10'h005);
    add_l(27'h00, 16'd3, 14'd1, 1'b0, 44'h0,   10'h000);
    add_l(27'h20, 16'd3, 14'd1, 1'b1, 44'h101, 10'h002);
    add_l(27'h40, 16'd5, 14'd1, 1'b1, 44'h102, 10'h003);
    add_l(27'h60, 16'd3, 14'd1, 1'b1, 44'h103, 10'h004);
    add_l(27'h80, 16'd5, 14'd1, 1'b1, 44'h104, 10'h005);
    add_f(27'h25, 16'd3, 44'h123, 10'h00F);
    add_l(27'h25, 16'd3, 14'd1, 1'b1, 44'h123, 10'h00F);
    add_f(27'h45, 16'd5, 44'h200, 10'h011);
    add_f(27'h65, 16'd3, 44'h201, 10'h012);
    add_f(27'h85, 16'd5, 44'h202, 10'h013);
    add_l(27'h25, 16'd3, 14'd1, 1'b1, 44'h123, 10'h00F);
    add_l(27'h45, 16'd5, 14'd1, 1'b1, 44'h200, 10'h011);
    add_l(27'h85, 16'd5, 14'd1, 1'b1, 44'h202, 10'h013);
    add_l(27'h25, 16'd5, 14'd1, 1'b0, 44'h0,   10'h000);
    add_l(27'h25, 16'd3, 14'd2, 1'b0, 44'h0,   10'h000);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst.busy",  64'(flush_busy_o), 64'd0);
    chk("rst.valid", 64'(lu_valid_o),   64'd0);
    chk("rst.hit",   64'(lu_hit_o),     64'd0);
    chk("rst.ppn",   64'(lu_ppn_o),     64'd0);
    chk("rst.perm",  64'(lu_perm_o),    64'd0);
    rst_ni = 1'b1;
    #1 chk("rst.ready", 64'(lu_ready_o), 64'd1);
    @(posedge clk); #1;

    foreach (tbl[i]) begin
      if (tbl[i].fill) do_fill(tbl[i].vpn, tbl[i].asid, tbl[i].vmid, tbl[i].ppn, tbl[i].perm);
      else do_lookup(tbl[i].vpn, tbl[i].asid, tbl[i].vmid, tbl[i].hit, tbl[i].ppn, tbl[i].perm,
                     $sformatf("tbl%0d", i));
    end
    @(posedge clk); #1;
    chk("strobe_one_cycle", 64'(lu_valid_o), 64'd0);

    // Lookup just before the flush request, then an ASID-3 walk with ignored fill/flush pokes
    fill_vpn_i = 27'h3F; fill_asid_i = 16'd5; fill_vmid_i = 14'd1; fill_ppn_i = 44'h777;
    do_lookup(27'h25, 16'd3, 14'd1, 1'b1, 44'h123, 10'h00F, "pre_flush");
    do_flush(1'b1, 16'd3, 1'b0, 14'd0, 1'b1, "flush_asid");
    do_lookup(27'h25, 16'd3, 14'd1, 1'b0, 44'h0,   10'h000, "fa.25");
    do_lookup(27'h20, 16'd3, 14'd1, 1'b0, 44'h0,   10'h000, "fa.20");
    do_lookup(27'h65, 16'd3, 14'd1, 1'b0, 44'h0,   10'h000, "fa.65");
    do_lookup(27'h40, 16'd5, 14'd1, 1'b1, 44'h102, 10'h003, "fa.40");
    do_lookup(27'h80, 16'd5, 14'd1, 1'b1, 44'h104, 10'h005, "fa.80");
    do_lookup(27'h45, 16'd5, 14'd1, 1'b1, 44'h200, 10'h011, "fa.45");
    do_lookup(27'h3F, 16'd5, 14'd1, 1'b0, 44'h0,   10'h000, "fa.dropped_fill");

    // flush + fill + lookup in one cycle: flush wins
    fill_valid_i = 1'b1; fill_vpn_i = 27'h33; fill_asid_i = 16'd3; fill_vmid_i = 14'd1; fill_ppn_i = 44'h555;
    lu_req_i = 1'b1; lu_vpn_i = 27'h40; lu_asid_i = 16'd5; lu_vmid_i = 14'd1;
    flush_by_asid_i = 1'b0; flush_by_vmid_i = 1'b0; flush_i = 1'b1;
    #1 chk("collide.ready", 64'(lu_ready_o), 64'd0);
    @(posedge clk); #1;
    fill_valid_i = 1'b0; lu_req_i = 1'b0; flush_i = 1'b0;
    chk("collide.valid", 64'(lu_valid_o), 64'd0);
    wait_flush(1'b0, "collide");
    m_flush(1'b0, 16'd0, 1'b0, 14'd0);
    do_lookup(27'h33, 16'd3, 14'd1, 1'b0, 44'h0, 10'h000, "collide.33");
    do_lookup(27'h40, 16'd5, 14'd1, 1'b0, 44'h0, 10'h000, "collide.40");

    // Reset at flush cycle 10 aborts the walk and wipes the table
    do_fill(27'h40, 16'd5, 14'd1, 44'h900, 10'h021);
    do_fill(27'h45, 16'd7, 14'd2, 44'h901, 10'h022);
    flush_by_asid_i = 1'b1; flush_asid_i = 16'd9; flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst_ni = 1'b0;
    #1;
    chk("midrst.busy",  64'(flush_busy_o), 64'd0);
    chk("midrst.valid", 64'(lu_valid_o),   64'd0);
    m_clear();
    repeat (2) @(posedge clk);
    #1 rst_ni = 1'b1;
    do_lookup(27'h40, 16'd5, 14'd1, 1'b0, 44'h0, 10'h000, "midrst.40");
    do_lookup(27'h45, 16'd7, 14'd2, 1'b0, 44'h0, 10'h000, "midrst.45");

    // Random traffic against the model, concentrated on a few sets to force evictions
    for (int i = 0; i < 400; i++) begin
      int r;
      logic [26:0] v;
      logic [15:0] a;
      logic [13:0] m;
      r = $urandom_range(0, 99);
      v = 27'(($urandom_range(0, 7) << 5) | $urandom_range(0, 3));
      a = ($urandom_range(0, 1) != 0) ? 16'd3 : 16'd5;
      m = ($urandom_range(0, 1) != 0) ? 14'd1 : 14'd2;
      if (r < 45) do_fill(v, a, m, 44'($urandom), 10'($urandom));
      else if (r < 96) model_lookup(v, a, m, $sformatf("rnd%0d", i));
      else do_flush(1'($urandom), a, 1'($urandom), m, 1'b0, $sformatf("rndflush%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
